// File: rtl/gpu_scanout_reader.sv
// Scanout reader: VGA-style raster timing, fetches the display buffer through a
// request/ack SRAM port into a prefetch FIFO and streams registered RGB pixels.
module gpu_scanout_reader #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int CHANNEL_BITS = 8,
  parameter int ADDR_BITS    = 20,
  parameter int BUF_OFFSET   = 307200,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      buffer_select_i,
  output logic                      rd_req_o,
  output logic [ADDR_BITS-1:0]      rd_addr_o,
  input  logic                      rd_ack_i,
  input  logic [3*CHANNEL_BITS-1:0] rd_data_i,
  output logic [3*CHANNEL_BITS-1:0] rgb_o,
  output logic                      de_o,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      frame_start_o,
  output logic                      underflow_o
);
  // state | meaning
  // IDLE  | no read outstanding; request when pixels remain and the FIFO has room
  // REQ   | read outstanding for the current frame; data is pushed on ack
  // DRAIN | read outstanding from the previous frame; data is dropped on ack

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int IW        = $clog2(PIX_TOTAL + 1);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int DW        = 3 * CHANNEL_BITS;

  localparam logic [HW-1:0]        H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]        H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]        HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]        HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]        V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]        V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]        VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]        VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [IW-1:0]        PIX_END = IW'(PIX_TOTAL);
  localparam logic [PW:0]          DEPTH   = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] OFFSET1 = ADDR_BITS'(BUF_OFFSET);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  logic [HW-1:0]        r_h_cnt;
  logic [VW-1:0]        r_v_cnt;
  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic                 r_disp_buf;
  logic                 r_rd_req;
  logic [ADDR_BITS-1:0] r_rd_addr;
  logic [DW-1:0]        r_fifo [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW:0]          r_count;
  logic [DW-1:0]        r_rgb;
  logic                 r_de;
  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_frame_start;
  logic                 r_underflow;

  logic                 w_active;
  logic                 w_hsync_n;
  logic                 w_vsync_n;
  logic                 w_boundary;
  logic                 w_push;
  logic                 w_pop;
  logic [ADDR_BITS-1:0] w_base;

  assign w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hsync_n  = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign w_vsync_n  = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
  assign w_boundary = (r_h_cnt == '0) && (r_v_cnt == VS_BEG);
  assign w_pop      = w_active && (r_count != '0);
  // the flush at a frame boundary wins over a push from the old frame
  assign w_push     = (r_state == S_REQ) && rd_ack_i && !w_boundary;
  assign w_base     = r_disp_buf ? OFFSET1 : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_disp_buf <= 1'b1;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      if (w_boundary) r_disp_buf <= ~buffer_select_i;
      unique case (r_state)
        S_IDLE: begin
          if (w_boundary) begin
            r_idx <= '0;
          end else if ((r_idx < PIX_END) && (r_count < DEPTH)) begin
            r_state   <= S_REQ;
            r_rd_req  <= 1'b1;
            r_rd_addr <= w_base + ADDR_BITS'(r_idx);
          end
        end
        S_REQ: begin
          if (w_boundary) begin
            r_idx <= '0;
            if (rd_ack_i) begin
              r_state  <= S_IDLE;
              r_rd_req <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (rd_ack_i) begin
            r_state  <= S_IDLE;
            r_rd_req <= 1'b0;
            r_idx    <= r_idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (rd_ack_i) begin
            r_state  <= S_IDLE;
            r_rd_req <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_rd_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= rd_data_i;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_boundary) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rgb         <= '0;
      r_de          <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_rgb         <= w_pop ? r_fifo[r_rd_ptr] : '0;
      r_de          <= w_active;
      r_hsync       <= w_hsync_n;
      r_vsync       <= w_vsync_n;
      r_frame_start <= w_boundary;
      r_underflow   <= w_active && (r_count == '0);
    end
  end

  assign rd_req_o      = r_rd_req;
  assign rd_addr_o     = r_rd_addr;
  assign rgb_o         = r_rgb;
  assign de_o          = r_de;
  assign hsync_o       = r_hsync;
  assign vsync_o       = r_vsync;
  assign frame_start_o = r_frame_start;
  assign underflow_o   = r_underflow;

endmodule

// File: tb/tb_gpu_scanout_reader.sv
// Bench for gpu_scanout_reader on a tiny 8x6 raster: a raster/FIFO reference model
// queues expected pixels; a separate monitor pops them whenever de_o is high.
module tb_gpu_scanout_reader;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NPIX = HA * VA;
  localparam int OFS = 100;

  logic        clk;
  logic        n_rst;
  logic        buffer_select_i;
  logic        rd_req_o;
  logic [19:0] rd_addr_o;
  logic        rd_ack_i;
  logic [23:0] rd_data_i;
  logic [23:0] rgb_o;
  logic        de_o, hsync_o, vsync_o, frame_start_o, underflow_o;

  gpu_scanout_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CHANNEL_BITS(8), .ADDR_BITS(20), .BUF_OFFSET(OFS), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .buffer_select_i(buffer_select_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_ack_i(rd_ack_i),
    .rd_data_i(rd_data_i), .rgb_o(rgb_o), .de_o(de_o), .hsync_o(hsync_o),
    .vsync_o(vsync_o), .frame_start_o(frame_start_o), .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [23:0] rgb; logic uf; } exp_t;

  int          n_err = 0, n_chk = 0;
  int          c;
  logic [23:0] mq[$];
  exp_t        eq[$];
  exp_t        mon_e;
  int          idx_m;
  bit          disp_m, pend, pend_disc, ack_prev, after_disc;
  logic [19:0] pend_addr;
  int          pend_wait, mode, ndisc, uf_cnt, first_fs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit act_p(input int p);
    return ((p % HT) < HA) && (((p / HT) % VT) < VA);
  endfunction
  function automatic bit hs_p(input int p);
    return !(((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS));
  endfunction
  function automatic bit vs_p(input int p);
    int v = (p / HT) % VT;
    return !((v >= VA + VF) && (v < VA + VF + VS));
  endfunction
  function automatic bit bnd_p(input int p);
    return ((p % HT) == 0) && (((p / HT) % VT) == VA + VF);
  endfunction

  function automatic int get_delay();
    case (mode)
      0:       return 0;
      1:       return 5;
      2:       return int'($urandom_range(0, 3));
      default: return 20;
    endcase
  endfunction

  task automatic model_reset();
    c = 0; mq.delete(); eq.delete(); idx_m = 0; disp_m = 1'b1;
    pend = 0; pend_disc = 0; ack_prev = 0; after_disc = 0; rd_ack_i = 1'b0;
  endtask

  // one model step per negedge; c is the raster position the DUT counters hold now
  task automatic step();
    bit          ack_this;
    logic [3:0]  nib;
    logic [23:0] d;
    logic [19:0] ea;
    exp_t        e;
    ack_this = 0;
    d = '0;
    if (c == 0) begin
      check("rst_de", de_o, 0); check("rst_hsync", hsync_o, 1);
      check("rst_vsync", vsync_o, 1); check("rst_fs", frame_start_o, 0);
      check("rst_req", rd_req_o, 0);
    end else begin
      check("de", de_o, act_p(c - 1)); check("hsync", hsync_o, hs_p(c - 1));
      check("vsync", vsync_o, vs_p(c - 1)); check("frame_start", frame_start_o, bnd_p(c - 1));
      if (frame_start_o && first_fs < 0) first_fs = c - 1;
      if (underflow_o) uf_cnt++;
    end
    if (ack_prev) begin
      check("req_drop_after_ack", rd_req_o, 0);
      rd_ack_i = 1'b0; ack_prev = 0;
    end else if (pend) begin
      check("req_held", rd_req_o, 1);
      check("addr_stable", rd_addr_o, pend_addr);
      if (pend_wait == 0) ack_this = 1; else pend_wait--;
    end else if (rd_req_o) begin
      ea = 20'((disp_m ? OFS : 0) + idx_m);
      check("req_allowed", (idx_m < NPIX), 1);
      check("req_addr", rd_addr_o, ea);
      if (after_disc) check("addr_after_drain", rd_addr_o, (disp_m ? OFS : 0));
      after_disc = 0;
      pend = 1; pend_addr = ea; pend_disc = 0;
      pend_wait = get_delay();
      if (pend_wait == 0) ack_this = 1; else pend_wait--;
    end
    if (ack_this) begin
      nib = 4'($urandom_range(0, 15));
      d = {nib, pend_addr};
      rd_data_i = d; rd_ack_i = 1'b1; ack_prev = 1;
    end
    if (act_p(c)) begin
      if (mq.size() > 0) begin e.rgb = mq.pop_front(); e.uf = 1'b0; end
      else begin e.rgb = '0; e.uf = 1'b1; end
      eq.push_back(e);
    end
    if (ack_this) begin
      if (pend_disc || bnd_p(c)) begin ndisc++; after_disc = 1; end
      else begin mq.push_back(d); idx_m++; end
      pend = 0;
    end
    if (bnd_p(c)) begin
      mq.delete(); idx_m = 0; disp_m = ~buffer_select_i;
      if (pend) pend_disc = 1;
    end
    c++;
  endtask

  task automatic run(input int n);
    repeat (n) begin @(negedge clk); step(); end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (de_o) begin
        if (eq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL pixel_expected: de_o high with no expected pixel at t=%0t", $time);
        end else begin
          mon_e = eq.pop_front();
          check("rgb", rgb_o, mon_e.rgb);
          check("underflow", underflow_o, mon_e.uf);
        end
      end else begin
        check("rgb_blank", rgb_o, 0);
        check("underflow_blank", underflow_o, 0);
      end
    end
  end

  initial begin
    int k;
    n_rst = 1'b0; rd_ack_i = 1'b0; rd_data_i = '0; buffer_select_i = 1'b0;
    mode = 0; ndisc = 0; uf_cnt = 0; first_fs = -1;
    repeat (3) @(negedge clk);
    check("rst_rgb", rgb_o, 0); check("rst_addr", rd_addr_o, 0);
    check("rst_uf", underflow_o, 0); check("rst_hs_in", hsync_o, 1);
    @(negedge clk);
    n_rst = 1'b1; model_reset(); step();
    run(33);
    check("first_frame_start_pos", first_fs, 32);
    uf_cnt = 0;
    run(2 * HT * VT);
    check("no_underflow_zero_wait", uf_cnt, 0);

    repeat (3) begin
      k = int'($urandom_range(1, HT * VT - 1));
      run(k);
      buffer_select_i = ~buffer_select_i;
      run(HT * VT - k);
    end

    mode = 1; uf_cnt = 0;
    run(2 * HT * VT);
    check("underflow_seen_slow", (uf_cnt > 0), 1);

    mode = 2;
    run(3 * HT * VT);

    mode = 3;
    run(3 * HT * VT);
    check("drain_seen", (ndisc > 0), 1);

    mode = 0;
    k = 0;
    while (!rd_req_o && k < 100) begin @(negedge clk); step(); k++; end
    check("req_before_reset", rd_req_o, 1);
    #2 n_rst = 1'b0;
    #1 check("req_async_drop", rd_req_o, 0);
    check("de_async_drop", de_o, 0);
    @(negedge clk);
    check("req_in_reset", rd_req_o, 0);
    rd_ack_i = 1'b0;
    @(negedge clk);
    n_rst = 1'b1; model_reset(); step();
    run(2 * HT * VT);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/gpu_scanout_reader.md
Name: gpu_scanout_reader

Overview:
- Downstream consumer of the double-buffered framebuffer that the GPU memory controller writes.
- Generates VGA-style raster timing and reads pixels from the display buffer, which is the buffer not currently selected for writing.
- Reads go through a request/ack SRAM read port into a small prefetch FIFO, then out as a registered RGB pixel stream with hsync/vsync/data-enable.
- The display buffer is swapped only at frame boundaries, so no tearing occurs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch clocks
H_SYNC, 96, hsync pulse clocks
H_BP, 48, horizontal back porch clocks
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch lines
V_SYNC, 2, vsync pulse lines
V_BP, 33, vertical back porch lines
CHANNEL_BITS, 8, bits per colour channel
ADDR_BITS, 20, SRAM word address width
BUF_OFFSET, 307200, word offset of buffer 1 (buffer 0 at 0)
FIFO_DEPTH, 8, prefetch FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
buffer_select_i  in  1  buffer currently being written by the memory controller
rd_req_o  out  1  SRAM read request
rd_addr_o  out  ADDR_BITS  SRAM read address
rd_ack_i  in  1  read accepted; rd_data_i valid this cycle
rd_data_i  in  3*CHANNEL_BITS  read pixel {r,g,b}
rgb_o  out  3*CHANNEL_BITS  output pixel
de_o  out  1  data enable (active area)
hsync_o  out  1  horizontal sync, active-low
vsync_o  out  1  vertical sync, active-low
frame_start_o  out  1  one-cycle pulse at frame boundary
underflow_o  out  1  one-cycle pulse, FIFO empty during active pixel

Behaviour:
- Reset values:
  - Outputs: rd_req_o=0, rd_addr_o=0, rgb_o=0, de_o=0, hsync_o=1, vsync_o=1, frame_start_o=0, underflow_o=0.
  - Internal: h_cnt=0, v_cnt=0, FIFO empty, fetch index=0, disp_buf=1.
- Timing counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps, 0..V_TOTAL-1, then wraps to 0.
  - Active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - de_o/hsync_o/vsync_o/rgb_o are all registered, with 1-cycle latency from the counter state and mutually aligned.
- Frame boundary (h_cnt==0 && v_cnt==V_ACTIVE+V_FP), all in the same cycle:
  - disp_buf <= ~buffer_select_i
  - FIFO flushed
  - fetch index <= 0
  - frame_start_o pulses
  - Changes to buffer_select_i at any other time have no effect on disp_buf.
- Fetch FSM with states IDLE, REQ, DRAIN:
  - IDLE->REQ when fetch index < H_ACTIVE*V_ACTIVE and (FIFO count) < FIFO_DEPTH.
  - In REQ: rd_req_o=1, rd_addr_o = (disp_buf ? BUF_OFFSET : 0) + fetch index. Address is held stable until rd_ack_i.
  - On rd_ack_i: push rd_data_i, increment fetch index, return to IDLE. No back-to-back request in the ack cycle.
  - At most one read outstanding.
  - Frame boundary while in REQ: go to DRAIN, keeping rd_req_o and rd_addr_o unchanged. On ack, discard the data and go to IDLE with the new frame's index 0.
- Pop:
  - Each active cycle pops one FIFO entry into rgb_o.
  - If the FIFO is empty: rgb_o=0, underflow_o pulses. No realignment until the next frame boundary.
  - Inactive cycles: rgb_o=0.
- Simultaneous push and pop on a full FIFO is legal; count stays the same.
- Fetch index wraps only at the frame boundary; it never exceeds H_ACTIVE*V_ACTIVE.
- Reset mid-read: rd_req_o drops immediately (asynchronous); a pending ack is ignored.

Test Plan (small params: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, BUF_OFFSET=100, FIFO_DEPTH=4):
- Reset:
  - Stimulus: reset, then release.
  - Required: outputs at reset values; first frame_start_o at cycle (V_ACTIVE+V_FP)*8 = 32 after release; hsync_o low for 2 clocks every 8.
- Zero-wait SRAM:
  - Stimulus: rd_ack_i asserted one cycle after every rd_req_o, rd_data_i=addr, buffer_select_i=0.
  - Required: addresses 100..111 requested each frame; rgb_o shows 100..111 in raster order under de_o; no underflow.
- Swap:
  - Stimulus: toggle buffer_select_i mid-frame.
  - Required: addresses stay on the current buffer until the next frame_start_o, then switch to 0..11.
- Slow SRAM:
  - Stimulus: ack delayed 5 cycles.
  - Required: underflow_o pulses on active cycles with an empty FIFO; rgb_o=0 on those cycles; rd_addr_o stable while rd_req_o is high.
- Outstanding read at frame boundary:
  - Stimulus: hold ack low across frame_start_o.
  - Required: rd_req_o stays high; the acked data is not pushed; the next request is offset+0.
- Async reset mid-request:
  - Stimulus: assert n_rst low while rd_req_o=1.
  - Required: rd_req_o=0 in the same cycle; after release, restart from h_cnt=0, v_cnt=0.
